hazard_fwd_ctrl: RTL

Combined forwarding and hazard-control unit for the 5-stage RISC-V pipeline. It replaces the purely combinational forwarding unit and adds:

- register-address-width parametrisation;
- load-use stall detection with a parametrised load latency, held by a stall FSM;
- taken-branch flush with defined priority over stalls;
- saturating stall and flush performance counters.

It sits beside the ID/EX and EX/MEM pipeline registers and drives the PC-write enable, the IF/ID write and flush controls, the ID/EX bubble insert, and the EX operand muxes.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_fwd_ctrl_fwd_select.sv | 32 +++
 rtl/hazard_fwd_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and types for the forwarding / hazard-control unit.
// Forward selects, stall FSM states and load-latency bounds.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam int LOAD_LAT_MIN = 1;
  localparam int LOAD_LAT_MAX = 7;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_select.sv
// One EX operand forward select: MEM beats WB, x0 never forwarded.
// Instantiated once per source operand.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  output logic [1:0]        sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_regwrite && (mem_rd != '0) && (mem_rd == rs);
  assign wb_hit  = wb_regwrite && (wb_rd != '0) && (wb_rd == rs);

  // Pick the youngest producer of the operand.
  always_comb begin
    sel = FWD_RF;
    priority case (1'b1)
      mem_hit: sel = FWD_MEM;
      wb_hit:  sel = FWD_WB;
      default: sel = FWD_RF;
    endcase
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding, load-use stall FSM, branch flush and perf counters.
// Branch flush always wins over a stall.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_regwrite,
  input  logic              wb_regwrite,
  input  logic              branch_taken,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  if (LOAD_LAT < LOAD_LAT_MIN || LOAD_LAT > LOAD_LAT_MAX) begin : g_lat_chk
    $error("hazard_fwd_ctrl: LOAD_LAT out of range 1..7");
  end

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  logic [1:0]       fa_raw;
  logic [1:0]       fb_raw;
  logic             luse;
  logic             stall;
  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .rs           (ex_rs1),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .sel          (fa_raw)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .rs           (ex_rs2),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .sel          (fb_raw)
  );

  assign luse = ex_memread && (ex_rd != '0) &&
                ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // In STALL the load has left EX, so luse no longer matters.
  assign stall = (state_q == STALL) || luse;

  // Pipeline control: reset quiets everything, branch beats stall.
  always_comb begin
    forward_a   = fa_raw;
    forward_b   = fb_raw;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst) begin
      forward_a  = FWD_RF;
      forward_b  = FWD_RF;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Stall FSM: first stall cycle in IDLE, the rest counted in STALL.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (branch_taken) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (luse && LOAD_LAT > 1) begin
            state_d = STALL;
            cnt_d   = LAT_M1;
          end
        end
        STALL: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !branch_taken && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (branch_taken && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
